// File: rtl/divider_pkg.sv
// Shared types for the multi-cycle DIV/DIVU unit: state encoding, operand/result
// bundles and the signed-magnitude helper used when an operation is loaded.
package divider_pkg;

    localparam int CPU_DATA_WIDTH    = 32;
    localparam int DIVIDE_ITERATIONS = CPU_DATA_WIDTH;

    typedef logic [CPU_DATA_WIDTH-1:0] CpuData;

    typedef enum logic [1:0] {
        WAITING_STATE,
        LOAD_STATE,
        DIVIDE_STATE,
        RETURN_STATE
    } State;

    typedef struct packed {
        logic   is_signed;
        CpuData dividend;
        CpuData divisor;
    } DivideRequest;

    typedef struct packed {
        CpuData quotient;
        CpuData remainder;
    } DivideResult;

    // Absolute value of a two's complement operand; unsigned operands pass through.
    function automatic CpuData magnitude(input CpuData value, input logic is_signed);
        return (is_signed && value[CPU_DATA_WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/divider_iteration.sv
// One restoring-division step: shift the partial remainder left, trial-subtract
// the divisor and shift the resulting quotient bit into the low half.
module divider_iteration #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] partial_remainder,
    input  logic [DATA_WIDTH-1:0]   divisor_magnitude,
    output logic [2*DATA_WIDTH-1:0] next_partial_remainder,
    output logic                    quotient_bit
);

    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] difference;

    // The shifted-out top bit is kept in trial so the compare sees DATA_WIDTH+1 bits;
    // the difference always fits in DATA_WIDTH bits because it is below the divisor.
    always_comb begin
        trial        = partial_remainder[2*DATA_WIDTH-1:DATA_WIDTH-1];
        difference   = trial[DATA_WIDTH-1:0] - divisor_magnitude;
        quotient_bit = (trial >= {1'b0, divisor_magnitude});
        if (quotient_bit) begin
            next_partial_remainder = {difference, partial_remainder[DATA_WIDTH-2:0], 1'b1};
        end else begin
            next_partial_remainder = {trial[DATA_WIDTH-1:0], partial_remainder[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one operation in flight,
// WAITING -> LOAD -> DIVIDE (ITERATIONS cycles) -> RETURN handshake with EX.
module divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ITERATIONS = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  divide_valid,
    input  logic                  divide_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  divide_ready,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int COUNT_WIDTH = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    State                    state;
    DivideRequest            request;
    CpuData                  divisor_magnitude;
    logic                    quotient_negative;
    logic                    remainder_negative;
    logic                    divide_by_zero;
    logic [COUNT_WIDTH-1:0]  counter;
    logic [2*DATA_WIDTH-1:0] partial_remainder;
    logic [2*DATA_WIDTH-1:0] next_partial_remainder;
    logic                    quotient_bit;
    CpuData                  quotient_magnitude;
    CpuData                  remainder_magnitude;
    DivideResult             final_result;

    divider_iteration #(
        .DATA_WIDTH(DATA_WIDTH)
    ) iteration (
        .partial_remainder     (partial_remainder),
        .divisor_magnitude     (divisor_magnitude),
        .next_partial_remainder(next_partial_remainder),
        .quotient_bit          (quotient_bit)
    );

    assign quotient_magnitude  = {next_partial_remainder[DATA_WIDTH-1:1], quotient_bit};
    assign remainder_magnitude = next_partial_remainder[2*DATA_WIDTH-1:DATA_WIDTH];

    // Division by zero bypasses sign correction so the result is the same for DIV and DIVU.
    always_comb begin
        final_result = '0;
        if (divide_by_zero) begin
            final_result.quotient  = '1;
            final_result.remainder = request.dividend;
        end else begin
            final_result.quotient  = quotient_negative  ? -quotient_magnitude  : quotient_magnitude;
            final_result.remainder = remainder_negative ? -remainder_magnitude : remainder_magnitude;
        end
    end

    // Handshake flags are registered alongside the state so they track it exactly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state              <= WAITING_STATE;
            divide_ready       <= 1'b1;
            result_valid       <= 1'b0;
            quotient           <= '0;
            remainder          <= '0;
            counter            <= '0;
            partial_remainder  <= '0;
            request            <= '0;
            divisor_magnitude  <= '0;
            quotient_negative  <= 1'b0;
            remainder_negative <= 1'b0;
            divide_by_zero     <= 1'b0;
        end else if (flush) begin
            state        <= WAITING_STATE;
            divide_ready <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            case (state)
                WAITING_STATE: begin
                    if (divide_valid) begin
                        request.is_signed <= divide_signed;
                        request.dividend  <= dividend;
                        request.divisor   <= divisor;
                        divide_ready      <= 1'b0;
                        state             <= LOAD_STATE;
                    end
                end
                LOAD_STATE: begin
                    divisor_magnitude  <= magnitude(request.divisor, request.is_signed);
                    partial_remainder  <= {{DATA_WIDTH{1'b0}},
                                           magnitude(request.dividend, request.is_signed)};
                    quotient_negative  <= request.is_signed &
                                          (request.dividend[DATA_WIDTH-1] ^ request.divisor[DATA_WIDTH-1]);
                    remainder_negative <= request.is_signed & request.dividend[DATA_WIDTH-1];
                    divide_by_zero     <= (request.divisor == '0);
                    counter            <= COUNT_WIDTH'(ITERATIONS - 1);
                    state              <= DIVIDE_STATE;
                end
                DIVIDE_STATE: begin
                    partial_remainder <= next_partial_remainder;
                    if (counter == '0) begin
                        quotient     <= final_result.quotient;
                        remainder    <= final_result.remainder;
                        result_valid <= 1'b1;
                        state        <= RETURN_STATE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RETURN_STATE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        divide_ready <= 1'b1;
                        state        <= WAITING_STATE;
                    end
                end
                default: begin
                    state        <= WAITING_STATE;
                    divide_ready <= 1'b1;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: latency, signed/unsigned results,
// edge operands, flush, backpressure and mid-operation reset.
module tb_divider;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        divide_valid;
    logic        divide_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        divide_ready;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int passed;
    int total;

    divider dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .divide_valid (divide_valid),
        .divide_signed(divide_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .divide_ready (divide_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch one operation from WAITING and return the cycle index where result_valid rose.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int cycles);
        divide_valid  = 1'b1;
        divide_signed = s;
        dividend      = a;
        divisor       = b;
        step();
        divide_valid  = 1'b0;
        cycles = 1;
        while (!result_valid && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if (divide_ready !== 1'b1 || result_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0)
            $display("[TB] FAIL reset_state: ready=%b valid=%b q=%h r=%h, expected 1 0 0 0",
                     divide_ready, result_valid, quotient, remainder);
        else passed++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned();
        int cycles;
        result_ready = 1'b1;
        run_op(32'd100, 32'd7, 1'b0, cycles);
        total++;
        if (cycles !== 34) $display("[TB] FAIL latency_100_7: got %0d, expected 34", cycles);
        else passed++;
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2)
            $display("[TB] FAIL udiv_100_7: q=%h r=%h, expected q=0000000e r=00000002", quotient, remainder);
        else passed++;
        step();
        total++;
        if (divide_ready !== 1'b1 || result_valid !== 1'b0)
            $display("[TB] FAIL waiting_after_return: ready=%b valid=%b, expected 1 0", divide_ready, result_valid);
        else passed++;
    endtask

    task automatic test_operands();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic        vs [7];
        logic [31:0] vq [7];
        logic [31:0] vr [7];
        int cycles;
        va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vs[0] = 1; vq[0] = 32'hFFFFFFFD; vr[0] = 32'hFFFFFFFF;
        va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1; vq[1] = 32'hFFFFFFFD; vr[1] = 32'd1;
        va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vs[2] = 1; vq[2] = 32'h80000000; vr[2] = 32'd0;
        va[3] = 32'd5;        vb[3] = 32'd0;        vs[3] = 0; vq[3] = 32'hFFFFFFFF; vr[3] = 32'd5;
        va[4] = 32'hFFFFFFFF; vb[4] = 32'd1;        vs[4] = 0; vq[4] = 32'hFFFFFFFF; vr[4] = 32'd0;
        va[5] = 32'hFFFFFF9C; vb[5] = 32'd7;        vs[5] = 1; vq[5] = 32'hFFFFFFF2; vr[5] = 32'hFFFFFFFE;
        va[6] = 32'hFFFFFFF9; vb[6] = 32'd2;        vs[6] = 0; vq[6] = 32'h7FFFFFFC; vr[6] = 32'd1;
        result_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vs[i], cycles);
            total++;
            if (cycles !== 34 || quotient !== vq[i] || remainder !== vr[i])
                $display("[TB] FAIL operands_%0d: %h/%h s=%b -> q=%h r=%h cyc=%0d, expected q=%h r=%h cyc=34",
                         i, va[i], vb[i], vs[i], quotient, remainder, cycles, vq[i], vr[i]);
            else passed++;
            step();
        end
    endtask

    task automatic test_flush();
        int cycles;
        logic seen_valid;
        seen_valid   = 1'b0;
        result_ready = 1'b1;
        divide_valid = 1'b1;
        divide_signed = 1'b0;
        dividend     = 32'd1000;
        divisor      = 32'd10;
        step();
        divide_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (result_valid) seen_valid = 1'b1;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        if (result_valid) seen_valid = 1'b1;
        total++;
        if (divide_ready !== 1'b1 || seen_valid !== 1'b0)
            $display("[TB] FAIL flush_cancel: ready=%b seen_valid=%b, expected 1 0", divide_ready, seen_valid);
        else passed++;
        run_op(32'd9, 32'd3, 1'b0, cycles);
        total++;
        if (cycles !== 34 || quotient !== 32'd3 || remainder !== 32'd0)
            $display("[TB] FAIL after_flush_9_3: q=%h r=%h cyc=%0d, expected q=00000003 r=00000000 cyc=34",
                     quotient, remainder, cycles);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int cycles;
        result_ready = 1'b0;
        run_op(32'd50, 32'd6, 1'b0, cycles);
        total++;
        if (cycles !== 34 || quotient !== 32'd8 || remainder !== 32'd2)
            $display("[TB] FAIL bp_result: q=%h r=%h cyc=%0d, expected q=00000008 r=00000002 cyc=34",
                     quotient, remainder, cycles);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            divide_valid = 1'b1;
            dividend     = 32'd77;
            divisor      = 32'd7;
            step();
            total++;
            if (result_valid !== 1'b1 || quotient !== 32'd8 || remainder !== 32'd2)
                $display("[TB] FAIL bp_hold_%0d: valid=%b q=%h r=%h, expected 1 00000008 00000002",
                         c, result_valid, quotient, remainder);
            else passed++;
        end
        result_ready = 1'b1;
        step();
        divide_valid = 1'b0;
        total++;
        if (divide_ready !== 1'b1 || result_valid !== 1'b0)
            $display("[TB] FAIL bp_release: ready=%b valid=%b, expected 1 0", divide_ready, result_valid);
        else passed++;
        step();
        total++;
        if (divide_ready !== 1'b1 || quotient !== 32'd8)
            $display("[TB] FAIL no_accept_in_return: ready=%b q=%h, expected 1 00000008", divide_ready, quotient);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        seen_valid   = 1'b0;
        result_ready = 1'b1;
        divide_valid = 1'b1;
        divide_signed = 1'b0;
        dividend     = 32'd1000;
        divisor      = 32'd10;
        step();
        divide_valid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total++;
        if (divide_ready !== 1'b1 || result_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0)
            $display("[TB] FAIL reset_mid: ready=%b valid=%b q=%h r=%h, expected 1 0 0 0",
                     divide_ready, result_valid, quotient, remainder);
        else passed++;
        for (int c = 0; c < 40; c++) begin
            if (result_valid) seen_valid = 1'b1;
            step();
        end
        total++;
        if (seen_valid !== 1'b0)
            $display("[TB] FAIL reset_mid_no_result: seen_valid=%b, expected 0", seen_valid);
        else passed++;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset_n       = 1'b0;
        flush         = 1'b0;
        divide_valid  = 1'b0;
        divide_signed = 1'b0;
        dividend      = 32'h0;
        divisor       = 32'h0;
        result_ready  = 1'b0;
        #1;
        test_reset();
        test_unsigned();
        test_operands();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
